ysyx_22041461_lsu: RTL and testbench
====================================

# ysyx_22041461_lsu

Parametrised load/store unit for the NPC memory stage. It accepts one load or store per handshake from the execute side, issues an aligned, byte-masked access on a valid/ready memory bus, and returns a size-extended load result or a store acknowledgement through a response handshake. Unlike the earlier single-cycle, full-width DPI memory stage, it supports multi-cycle memory latency, B/H/W/D access sizes with sign/zero extension, lane-shifted write data with exact byte masks, and misalignment detection.

## Interface
- DATA_W, 64, bus and register data width; legal values 32 or 64.
- ADDR_W, 64, address width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  upstream request valid.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0=B, 1=H, 2=W, 3=D.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts request.
- mem_we  out  1  bus write enable.
- mem_addr  out  ADDR_W  req_addr with low log2(DATA_W/8) bits cleared.
- mem_wdata  out  DATA_W  store data shifted into its byte lanes.
- mem_wmask  out  DATA_W/8  byte-enable mask.
- mem_rsp_valid  in  1  bus read data / write ack valid (one-cycle pulse).
- mem_rdata  in  DATA_W  bus read data, full aligned word.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream consumes result.
- rsp_data  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal-size access.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch all req_* fields. If misaligned (off not multiple of 2^size) or size=D with DATA_W=32 -> RESP with err=1, no bus access. Else -> REQ.
- REQ: mem_req_valid=1; mem_addr/we/wdata/wmask stable until mem_req_ready. On mem_req_ready -> WAIT.
- WAIT: on mem_rsp_valid, capture mem_rdata -> RESP.
- RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_ready. On rsp_ready -> IDLE.
- off = addr low log2(DATA_W/8) bits; nbytes = 2^size.
- mem_wmask = ((1<<nbytes)-1) << off; 0 for loads.
- mem_wdata = req_wdata << (8*off), bits outside lanes zero.
- Load: r = mem_rdata >> (8*off); keep low 8*nbytes bits; bit 8*nbytes-1 replicated upward unless unsigned. Size=D (DATA_W=64) passes through.
- mem_rsp_valid ignored outside WAIT; exactly one outstanding bus transaction.

## Timing
- Reset: state IDLE; req_ready=0 while rst high, 1 the cycle after release; mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask, rsp_valid, rsp_data, rsp_err all 0.
- Minimum latency, zero-wait bus: accept cycle 0, mem_req_valid cycle 1 (ready same cycle), mem_rsp_valid earliest cycle 2, rsp_valid cycle 3.
- Error path: accept cycle 0, rsp_valid+rsp_err cycle 1.
- Next request accepted the cycle after the rsp_valid&&rsp_ready handshake (no overlap).
- mem_rsp_valid in the same cycle as the mem_req_ready handshake is ignored; the bus returns it at least one cycle later.
- Backpressure: mem_req_ready or rsp_ready low holds state and outputs indefinitely.
- Reset mid-operation (any state): return to IDLE next edge, drop mem_req_valid/rsp_valid, discard captured data; a late mem_rsp_valid is ignored.

## Test plan
- Load B signed, addr=0x8000_0003, mem_rdata=0x0000_0000_8000_0000 -> mem_addr=0x8000_0000, mem_wmask=0, rsp_data=0xFFFF_FFFF_FFFF_FF80, err=0, rsp_valid at cycle 3.
- Load W unsigned, addr=0x8000_0004, mem_rdata=0xDEAD_BEEF_0000_0000 -> rsp_data=0x0000_0000_DEAD_BEEF; signed variant -> 0xFFFF_FFFF_DEAD_BEEF.
- Store H, addr=0x8000_0006, wdata=0x1234 -> mem_we=1, mem_wmask=0xC0, mem_wdata=0x1234_0000_0000_0000; rsp_data=0 after ack.
- Misaligned load W at 0x8000_0002 -> rsp_err=1 at cycle 1, mem_req_valid never asserted.
- Backpressure: mem_req_ready low 3 cycles, mem_rsp after 4 more, rsp_ready low 2 cycles -> outputs stable throughout, single bus request, req_ready low until final handshake.
- Reset asserted in WAIT, then stray mem_rsp_valid -> all outputs 0, IDLE, no rsp_valid; DATA_W=32 instance: size D -> rsp_err=1.

Source files
------------

// File: rtl/ysyx_22041461_lsu.sv
// Load/store unit for the NPC memory stage: one outstanding access on a valid/ready bus,
// byte-lane placement of store data, size/sign extension of load data, misalignment errors.
module ysyx_22041461_lsu #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_err
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [3:0] NB4 = 4'(NB);

  // IDLE accept | REQ bus request held | WAIT bus data | RESP result held
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NB-1:0]     wmask_q, wmask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [OFF_W-1:0]  req_off;
  logic [3:0]        req_nbytes;
  logic              req_bad;
  logic [NB-1:0]     lane_mask;
  logic [DATA_W-1:0] wdata_shift, lane_data;
  logic [DATA_W-1:0] ld_shift, ld_ext;
  logic [6:0]        ld_bits;
  logic              ld_sign;

  assign req_off     = req_addr[OFF_W-1:0];
  assign req_nbytes  = 4'd1 << req_size;
  assign req_bad     = ((req_off & OFF_W'(req_nbytes - 4'd1)) != '0) || (req_nbytes > NB4);
  assign wdata_shift = req_wdata << {req_off, 3'b000};

  always_comb begin
    lane_mask = '0;
    lane_data = '0;
    for (int i = 0; i < NB; i++) begin
      lane_mask[i] = req_we && (i >= int'(req_off)) && (i < int'(req_off) + int'(req_nbytes));
      lane_data[8*i +: 8] = lane_mask[i] ? wdata_shift[8*i +: 8] : 8'h00;
    end
  end

  // Extension is applied at capture so rsp_data is a plain register in RESP.
  assign ld_shift = mem_rdata >> {off_q, 3'b000};
  assign ld_bits  = 7'd8 << size_q;

  always_comb begin
    ld_sign = 1'b0;
    case (size_q)
      2'd0:    ld_sign = ld_shift[7];
      2'd1:    ld_sign = ld_shift[15];
      2'd2:    ld_sign = ld_shift[31];
      default: ld_sign = ld_shift[DATA_W-1];
    endcase
    ld_ext = ld_shift;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= int'(ld_bits)) ld_ext[i] = ~uns_q & ld_sign;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = req_off;
          addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wdata_d = lane_data;
          wmask_d = lane_mask;
          rdata_d = '0;
          err_d   = req_bad;
          state_d = req_bad ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          rdata_d = we_q ? '0 : ld_ext;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE) && !rst;
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_data      = rdata_q;
  assign rsp_err       = err_q;

endmodule

// File: tb/tb_ysyx_22041461_lsu.sv
// Scoreboard bench for the LSU: a bus model and a response monitor check the DUT
// against a byte-arithmetic reference model; a second 32-bit instance covers the narrow bus.
module tb_ysyx_22041461_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_data;

  logic        s_req_valid, s_req_ready, s_req_we, s_req_unsigned;
  logic [1:0]  s_req_size;
  logic [63:0] s_req_addr, s_mem_addr;
  logic [31:0] s_req_wdata, s_mem_wdata, s_mem_rdata, s_rsp_data;
  logic        s_mem_req_valid, s_mem_req_ready, s_mem_we, s_mem_rsp_valid;
  logic [3:0]  s_mem_wmask;
  logic        s_rsp_valid, s_rsp_ready, s_rsp_err;

  ysyx_22041461_lsu #(.DATA_W(64), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  ysyx_22041461_lsu #(.DATA_W(32), .ADDR_W(64)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(s_req_we), .req_size(s_req_size),
    .req_unsigned(s_req_unsigned), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
    .mem_req_valid(s_mem_req_valid), .mem_req_ready(s_mem_req_ready), .mem_we(s_mem_we),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_wmask(s_mem_wmask),
    .mem_rsp_valid(s_mem_rsp_valid), .mem_rdata(s_mem_rdata),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data), .rsp_err(s_rsp_err)
  );

  typedef struct { logic err; logic [63:0] data; } rsp_t;
  typedef struct { logic [63:0] addr; logic we; logic [7:0] mask; logic [63:0] wdata; logic [63:0] rdata; } bus_t;

  rsp_t exp_rsp[$];
  bus_t exp_bus[$];
  int   n_cmp = 0, n_bad = 0;
  int   rdly_cfg = -1, rspdly_cfg = -1, hold_cfg = -1;
  bit   bus_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual=%s required=none", name, what);
  endtask

  // Reference: bytes are selected from the aligned word by plain shifts and masks.
  function automatic void model(input logic we, input logic [1:0] sz, input logic un,
                                input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                                input int dw, output logic err, output logic [63:0] data,
                                output logic [63:0] maddr, output logic [7:0] mask,
                                output logic [63:0] mwd);
    int nb, bus_b, off;
    logic [63:0] low, dmask, v;
    nb    = 1 << sz;
    bus_b = dw / 8;
    off   = int'(a[2:0]) % bus_b;
    low   = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    err   = ((off % nb) != 0) || (nb > bus_b);
    maddr = a - 64'(off);
    mask  = we ? 8'(((1 << nb) - 1) << off) : 8'h00;
    mwd   = we ? (((wd & low) << (8 * off)) & dmask) : 64'd0;
    v     = (rd >> (8 * off)) & low;
    if (!un && v[8*nb-1]) v = v | ~low;
    data  = (err || we) ? 64'd0 : (v & dmask);
  endfunction

  task automatic check_bus(input bus_t b);
    chk("bus_addr",  mem_addr, b.addr);
    chk("bus_we",    64'(mem_we), 64'(b.we));
    chk("bus_wmask", 64'(mem_wmask), 64'(b.mask));
    chk("bus_wdata", mem_wdata, b.wdata);
  endtask

  // Bus model: random request stall, random response latency, stray rsp pulses outside WAIT.
  initial begin
    int ph, cnt;
    bus_t cur;
    ph = 0;
    cnt = 0;
    cur = '{default: '0};
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_en) begin
        mem_rsp_valid = 1'b0;
        mem_rdata = {$urandom, $urandom};
        if (rst) begin
          ph = 0;
          mem_req_ready = 1'b0;
        end else begin
          case (ph)
            0: begin
              mem_rsp_valid = ($urandom_range(0, 3) == 0);
              if (mem_req_valid) begin
                if (exp_bus.size() == 0) fail("bus_unexpected_req", "mem_req_valid");
                else begin
                  cur = exp_bus.pop_front();
                  check_bus(cur);
                  cnt = (rdly_cfg < 0) ? int'($urandom_range(0, 3)) : rdly_cfg;
                  if (cnt == 0) begin mem_req_ready = 1'b1; ph = 2; end
                  else ph = 1;
                end
              end
            end
            1: begin
              mem_rsp_valid = ($urandom_range(0, 3) == 0);
              check_bus(cur);
              cnt--;
              if (cnt == 0) begin mem_req_ready = 1'b1; ph = 2; end
            end
            2: begin
              mem_req_ready = 1'b0;
              chk("bus_single_req", 64'(mem_req_valid), 64'd0);
              cnt = (rspdly_cfg < 0) ? int'($urandom_range(0, 3)) : rspdly_cfg;
              if (cnt == 0) begin
                mem_rsp_valid = 1'b1; mem_rdata = cur.rdata; ph = 0;
              end else begin
                cnt--; ph = 3;
              end
            end
            default: begin
              chk("bus_single_req", 64'(mem_req_valid), 64'd0);
              if (cnt == 0) begin
                mem_rsp_valid = 1'b1; mem_rdata = cur.rdata; ph = 0;
              end else cnt--;
            end
          endcase
        end
      end
    end
  end

  // Response monitor: random hold-off, compares every cycle the result is presented.
  initial begin
    int h;
    bit busy;
    rsp_t e;
    h = 0;
    busy = 1'b0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0;
        rsp_ready = 1'b0;
      end else if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          fail("rsp_unexpected", "rsp_valid");
          rsp_ready = 1'b1;
        end else begin
          if (!busy) begin
            busy = 1'b1;
            h = (hold_cfg < 0) ? int'($urandom_range(0, 3)) : hold_cfg;
          end
          e = exp_rsp[0];
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          if (h == 0) begin
            rsp_ready = 1'b1;
            void'(exp_rsp.pop_front());
            busy = 1'b0;
          end else begin
            rsp_ready = 1'b0;
            h--;
          end
        end
      end else rsp_ready = 1'b0;
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic un,
                       input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd);
    rsp_t r;
    bus_t b;
    logic e_err, e_we;
    logic [63:0] e_data, e_addr, e_wd;
    logic [7:0] e_mask;
    int g;
    g = 0;
    e_we = we;
    model(we, sz, un, a, wd, rd, 64, e_err, e_data, e_addr, e_mask, e_wd);
    r.err = e_err; r.data = e_data;
    b.addr = e_addr; b.we = e_we; b.mask = e_mask; b.wdata = e_wd; b.rdata = rd;
    while (!req_ready && g < 200) begin @(negedge clk); g++; end
    if (!req_ready) begin fail("issue_wait", "req_ready stuck low"); return; end
    exp_rsp.push_back(r);
    if (!e_err) exp_bus.push_back(b);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
  endtask

  task automatic wait_rsp_lat(input string name, input int exp_lat);
    int c;
    c = 1;
    while (!rsp_valid && c < 30) begin @(negedge clk); c++; end
    chk(name, 64'(c), 64'(exp_lat));
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (!(req_ready && exp_rsp.size() == 0 && exp_bus.size() == 0) && g < 300) begin
      @(negedge clk); g++;
    end
    if (g >= 300) fail("wait_idle", "unit never drained");
  endtask

  task automatic set_cfg(input int rd, input int rs, input int hd);
    rdly_cfg = rd; rspdly_cfg = rs; hold_cfg = hd;
  endtask

  task automatic run32(input string name, input logic we, input logic [1:0] sz, input logic un,
                       input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd);
    logic e_err;
    logic [63:0] e_data, e_addr, e_wd;
    logic [7:0] e_mask;
    bit got;
    got = 1'b0;
    model(we, sz, un, a, wd, rd, 32, e_err, e_data, e_addr, e_mask, e_wd);
    chk({name, "_ready"}, 64'(s_req_ready), 64'd1);
    s_req_valid = 1'b1; s_req_we = we; s_req_size = sz; s_req_unsigned = un;
    s_req_addr = a; s_req_wdata = wd[31:0];
    @(negedge clk);
    s_req_valid = 1'b0;
    for (int c = 1; c < 20 && !got; c++) begin
      s_mem_rsp_valid = 1'b0;
      if (s_mem_req_valid && !s_mem_req_ready) begin
        chk({name, "_bus_on_error"}, 64'(e_err), 64'd0);
        chk({name, "_addr"},  s_mem_addr, e_addr);
        chk({name, "_wmask"}, 64'(s_mem_wmask), 64'(e_mask));
        chk({name, "_wdata"}, 64'(s_mem_wdata), e_wd);
        s_mem_req_ready = 1'b1;
      end else if (s_mem_req_ready) begin
        s_mem_req_ready = 1'b0;
        s_mem_rsp_valid = 1'b1;
        s_mem_rdata = rd[31:0];
      end
      if (s_rsp_valid) begin
        chk({name, "_data"}, 64'(s_rsp_data), e_data);
        chk({name, "_err"},  64'(s_rsp_err), 64'(e_err));
        chk({name, "_lat"},  64'(c), e_err ? 64'd1 : 64'd3);
        s_rsp_ready = 1'b1;
        got = 1'b1;
      end
      @(negedge clk);
    end
    s_rsp_ready = 1'b0;
    s_mem_rsp_valid = 1'b0;
    if (!got) fail({name, "_timeout"}, "no rsp_valid");
  endtask

  initial begin
    logic        we, un;
    logic [1:0]  sz;
    logic [63:0] a;
    int          g;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    s_req_valid = 1'b0; s_req_we = 1'b0; s_req_size = 2'd0; s_req_unsigned = 1'b0;
    s_req_addr = '0; s_req_wdata = '0; s_mem_req_ready = 1'b0; s_mem_rsp_valid = 1'b0;
    s_mem_rdata = '0; s_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    set_cfg(0, 0, 0);
    issue(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000);
    wait_rsp_lat("lat_load_b", 3);
    issue(1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'd0, 64'hDEAD_BEEF_0000_0000);
    wait_rsp_lat("lat_load_wu", 3);
    issue(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'd0, 64'hDEAD_BEEF_0000_0000);
    issue(1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'hFFFF_FFFF_FFFF_1234, 64'h0123_4567_89AB_CDEF);
    issue(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'd0, 64'd0);
    wait_rsp_lat("lat_misaligned", 1);
    issue(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'd0, 64'h8765_4321_0FED_CBA9);
    wait_idle();

    set_cfg(3, 4, 2);
    issue(1'b1, 2'd3, 1'b0, 64'h8000_0010, 64'hA5A5_5A5A_C3C3_3C3C, 64'd0);
    g = 1;
    while (!req_ready && g < 40) begin @(negedge clk); g++; end
    chk("bp_next_accept_cycle", 64'(g), 64'd13);
    wait_idle();

    bus_en = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'h8000_0020;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_test_req_issued", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("midrst_mem_we", 64'(mem_we), 64'd0);
    chk("midrst_mem_addr", mem_addr, 64'd0);
    chk("midrst_mem_wdata", mem_wdata, 64'd0);
    chk("midrst_mem_wmask", 64'(mem_wmask), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rsp_data", rsp_data, 64'd0);
    chk("midrst_rsp_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("midrst_idle_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
      chk("midrst_no_bus", 64'(mem_req_valid), 64'd0);
      @(negedge clk);
    end
    bus_en = 1'b1;

    set_cfg(-1, -1, -1);
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      sz = 2'($urandom);
      un = 1'($urandom);
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      issue(we, sz, un, a, {$urandom, $urandom}, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_idle();

    run32("n32_size_d", 1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'd0, 64'h1234_5678);
    run32("n32_load_h", 1'b0, 2'd1, 1'b0, 64'h8000_0002, 64'd0, 64'h8001_0000);
    run32("n32_store_b", 1'b1, 2'd0, 1'b0, 64'h8000_0001, 64'h0000_FFAB, 64'd0);
    run32("n32_load_wu", 1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'd0, 64'hF234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
